// File: rtl/conv_1x1_pkg.sv
// Shared definitions for the 1x1 convolution path: scheduler FSM states and
// default layer geometry.
package conv_1x1_pkg;

    localparam int unsigned DEF_IMAGE_SIZE   = 36;
    localparam int unsigned DEF_IMAGE_WIDTH  = 6;
    localparam int unsigned DEF_NUM_CHANNELS = 4;
    localparam int unsigned DEF_NUM_FILTERS  = 8;
    localparam int unsigned DEF_PIPE_LATENCY = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN,
        DONE
    } sched_state_t;

endpackage

// File: rtl/conv_1x1_scheduler_if.sv
// Command/status and memory-read strobes between the layer controller, the
// scheduler (master) and the buffer/MAC path (slave).
interface conv_1x1_scheduler_if
    import conv_1x1_pkg::*;
#(
    parameter int unsigned FM_ADDR_WIDTH = $clog2(DEF_IMAGE_SIZE * DEF_NUM_CHANNELS),
    parameter int unsigned W_ADDR_WIDTH  = $clog2(DEF_NUM_FILTERS * DEF_NUM_CHANNELS)
);
    logic                     start;
    logic                     stride2_in;
    logic                     abort;
    logic                     stall;
    logic                     busy;
    logic                     done;
    logic                     stride2;
    logic                     fm_rd_en;
    logic [FM_ADDR_WIDTH-1:0] fm_rd_addr;
    logic                     w_rd_en;
    logic [W_ADDR_WIDTH-1:0]  w_rd_addr;
    logic                     load_weights;
    logic                     acc_first;
    logic                     acc_last;

    modport master (
        input  start, stride2_in, abort, stall,
        output busy, done, stride2, fm_rd_en, fm_rd_addr,
               w_rd_en, w_rd_addr, load_weights, acc_first, acc_last
    );

    modport slave (
        output start, stride2_in, abort, stall,
        input  busy, done, stride2, fm_rd_en, fm_rd_addr,
               w_rd_en, w_rd_addr, load_weights, acc_first, acc_last
    );
endinterface

// File: rtl/conv_1x1_addr_gen.sv
// Nested pixel/channel/filter counters for the 1x1 scheduler, with wrap flags
// and the feature/weight addresses derived from them.
module conv_1x1_addr_gen
    import conv_1x1_pkg::*;
#(
    parameter int unsigned IMAGE_SIZE       = DEF_IMAGE_SIZE,
    parameter int unsigned NUM_CHANNELS     = DEF_NUM_CHANNELS,
    parameter int unsigned NUM_FILTERS      = DEF_NUM_FILTERS,
    parameter int unsigned CNT_WIDTH_BUFFER = $clog2(IMAGE_SIZE),
    parameter int unsigned CH_WIDTH         = $clog2(NUM_CHANNELS),
    parameter int unsigned FLT_WIDTH        = $clog2(NUM_FILTERS),
    parameter int unsigned FM_ADDR_WIDTH    = $clog2(IMAGE_SIZE * NUM_CHANNELS),
    parameter int unsigned W_ADDR_WIDTH     = $clog2(NUM_FILTERS * NUM_CHANNELS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     step,
    output logic                     pix_wrap,
    output logic                     ch_first,
    output logic                     ch_last,
    output logic                     flt_last,
    output logic [FM_ADDR_WIDTH-1:0] fm_addr,
    output logic [W_ADDR_WIDTH-1:0]  w_addr
);
    logic [CNT_WIDTH_BUFFER-1:0] pix;
    logic [CH_WIDTH-1:0]         ch;
    logic [FLT_WIDTH-1:0]        flt;

    assign pix_wrap = (pix == CNT_WIDTH_BUFFER'(IMAGE_SIZE - 1));
    assign ch_first = (ch == '0);
    assign ch_last  = (ch == CH_WIDTH'(NUM_CHANNELS - 1));
    assign flt_last = (flt == FLT_WIDTH'(NUM_FILTERS - 1));

    // Constant multipliers: these reduce to shift/add networks.
    assign fm_addr = FM_ADDR_WIDTH'(ch) * FM_ADDR_WIDTH'(IMAGE_SIZE) + FM_ADDR_WIDTH'(pix);
    assign w_addr  = W_ADDR_WIDTH'(flt) * W_ADDR_WIDTH'(NUM_CHANNELS) + W_ADDR_WIDTH'(ch);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix <= '0;
            ch  <= '0;
            flt <= '0;
        end else if (clear) begin
            pix <= '0;
            ch  <= '0;
            flt <= '0;
        end else if (step) begin
            if (pix_wrap) begin
                pix <= '0;
                // ch/flt saturate on the final plane so the last addresses stay visible.
                if (!ch_last) begin
                    ch <= ch + CH_WIDTH'(1);
                end else if (!flt_last) begin
                    ch  <= '0;
                    flt <= flt + FLT_WIDTH'(1);
                end
            end else begin
                pix <= pix + CNT_WIDTH_BUFFER'(1);
            end
        end
    end
endmodule

// File: rtl/conv_1x1_scheduler.sv
// Layer sequencer for the 1x1 convolution: per (filter, channel) one weight
// load slot followed by one streamed channel plane, then pipeline drain.
module conv_1x1_scheduler
    import conv_1x1_pkg::*;
#(
    parameter int unsigned IMAGE_SIZE       = DEF_IMAGE_SIZE,
    parameter int unsigned IMAGE_WIDTH      = DEF_IMAGE_WIDTH,
    parameter int unsigned NUM_CHANNELS     = DEF_NUM_CHANNELS,
    parameter int unsigned NUM_FILTERS      = DEF_NUM_FILTERS,
    parameter int unsigned PIPE_LATENCY     = DEF_PIPE_LATENCY,
    parameter int unsigned CNT_WIDTH_BUFFER = $clog2(IMAGE_SIZE),
    parameter int unsigned CH_WIDTH         = $clog2(NUM_CHANNELS),
    parameter int unsigned FLT_WIDTH        = $clog2(NUM_FILTERS),
    parameter int unsigned FM_ADDR_WIDTH    = $clog2(IMAGE_SIZE * NUM_CHANNELS),
    parameter int unsigned W_ADDR_WIDTH     = $clog2(NUM_FILTERS * NUM_CHANNELS)
) (
    input  logic                 clk,
    input  logic                 reset,
    conv_1x1_scheduler_if.master bus
);
    localparam int unsigned DRAIN_W = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;

    if (IMAGE_SIZE % IMAGE_WIDTH != 0) begin : g_geom_check
        $error("IMAGE_SIZE must be a whole number of IMAGE_WIDTH rows");
    end

    sched_state_t               state_q, state_d;
    logic [DRAIN_W-1:0]         drain_q, drain_d;
    logic                       accept, cnt_clear;
    logic                       step_load, step_read, step_done;
    logic                       pix_wrap, ch_first, ch_last, flt_last;
    logic [FM_ADDR_WIDTH-1:0]   fm_addr, fm_addr_q;
    logic [W_ADDR_WIDTH-1:0]    w_addr, w_addr_q;
    logic                       busy_q, done_q, stride2_q;
    logic                       fm_rd_en_q, w_rd_en_q, load_q, acc_first_q, acc_last_q;

    conv_1x1_addr_gen #(
        .IMAGE_SIZE       (IMAGE_SIZE),
        .NUM_CHANNELS     (NUM_CHANNELS),
        .NUM_FILTERS      (NUM_FILTERS),
        .CNT_WIDTH_BUFFER (CNT_WIDTH_BUFFER),
        .CH_WIDTH         (CH_WIDTH),
        .FLT_WIDTH        (FLT_WIDTH),
        .FM_ADDR_WIDTH    (FM_ADDR_WIDTH),
        .W_ADDR_WIDTH     (W_ADDR_WIDTH)
    ) u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .step     (step_read),
        .pix_wrap (pix_wrap),
        .ch_first (ch_first),
        .ch_last  (ch_last),
        .flt_last (flt_last),
        .fm_addr  (fm_addr),
        .w_addr   (w_addr)
    );

    // Each edge decides the step shown on the registered outputs next cycle;
    // a stalled edge performs nothing, so the pending step simply waits.
    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        accept    = 1'b0;
        cnt_clear = 1'b0;
        step_load = 1'b0;
        step_read = 1'b0;
        step_done = 1'b0;
        if (state_q == IDLE) begin
            if (bus.start) begin
                accept    = 1'b1;
                cnt_clear = 1'b1;
                step_load = !bus.stall;
                state_d   = bus.stall ? LOAD_W : STREAM;
            end
        end else if (bus.abort) begin
            state_d   = IDLE;
            drain_d   = '0;
            cnt_clear = 1'b1;
        end else if (!bus.stall) begin
            case (state_q)
                LOAD_W: begin
                    step_load = 1'b1;
                    state_d   = STREAM;
                end
                STREAM: begin
                    step_read = 1'b1;
                    if (pix_wrap) begin
                        state_d = (ch_last && flt_last) ? DRAIN : LOAD_W;
                        drain_d = '0;
                    end
                end
                DRAIN: begin
                    if (drain_q == DRAIN_W'(PIPE_LATENCY - 1)) begin
                        state_d = DONE;
                        drain_d = '0;
                    end else begin
                        drain_d = drain_q + DRAIN_W'(1);
                    end
                end
                DONE: begin
                    step_done = 1'b1;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            drain_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stride2_q   <= 1'b0;
            fm_rd_en_q  <= 1'b0;
            w_rd_en_q   <= 1'b0;
            load_q      <= 1'b0;
            acc_first_q <= 1'b0;
            acc_last_q  <= 1'b0;
            fm_addr_q   <= '0;
            w_addr_q    <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            busy_q      <= (state_d != IDLE) || step_done;
            done_q      <= step_done;
            fm_rd_en_q  <= step_read;
            w_rd_en_q   <= step_load;
            load_q      <= step_load;
            acc_first_q <= step_read && ch_first;
            acc_last_q  <= step_read && ch_last;
            if (accept) begin
                stride2_q <= bus.stride2_in;
            end
            if (step_read) begin
                fm_addr_q <= fm_addr;
            end
            // Counters clear on the same edge as the first load, so force address 0.
            if (step_load) begin
                w_addr_q <= accept ? '0 : w_addr;
            end
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.stride2      = stride2_q;
    assign bus.fm_rd_en     = fm_rd_en_q;
    assign bus.fm_rd_addr   = fm_addr_q;
    assign bus.w_rd_en      = w_rd_en_q;
    assign bus.w_rd_addr    = w_addr_q;
    assign bus.load_weights = load_q;
    assign bus.acc_first    = acc_first_q;
    assign bus.acc_last     = acc_last_q;
endmodule
